// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style panel model: opcodes, DDRAM map
// constants and address-counter helpers.
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE  = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_WRAP = 7'h27;
  localparam logic [6:0] LINE2_WRAP = 7'h67;

  typedef enum logic [3:0] {
    OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPLAY,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } op_e;

  typedef struct packed {
    logic dl;
    logic n;
    logic f;
    logic d;
    logic c;
    logic b;
  } panel_cfg_t;

  // Highest set bit selects the instruction.
  function automatic op_e decode_op(input logic [7:0] d);
    if (d[7]) return OP_DDRAM;
    if (d[6]) return OP_CGRAM;
    if (d[5]) return OP_FUNC;
    if (d[4]) return OP_SHIFT;
    if (d[3]) return OP_DISPLAY;
    if (d[2]) return OP_ENTRY;
    if (d[1]) return OP_HOME;
    if (d[0]) return OP_CLEAR;
    return OP_NOP;
  endfunction

  // Two-line map: addresses past a line's wrap limit (0x28-0x3F, 0x68-0x7F)
  // fall through to the next line's base on increment.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac >= LINE2_WRAP) return LINE1_BASE;
      if (ac >= LINE1_WRAP && ac < LINE2_BASE) return LINE2_BASE;
      return ac + 7'd1;
    end
    if (ac == LINE1_BASE) return LINE2_WRAP;
    if (ac == LINE2_BASE) return LINE1_WRAP;
    return ac - 7'd1;
  endfunction

  function automatic logic on_screen(input logic [6:0] ac);
    return (ac[5:4] == 2'b00);
  endfunction

  function automatic logic [4:0] cell_idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_panel_responder_ddram.sv
// 32x8 display RAM: cells 0-15 are line 1, 16-31 line 2; flattened with
// cell 0 in the top byte.
module lcd_ddram_buffer
  import lcd_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic         clr_i,
  input  logic [4:0]   widx_i,
  input  logic [7:0]   wdata_i,
  input  logic [4:0]   ridx_i,
  output logic [7:0]   rdata_o,
  output logic [255:0] flat_o
);

  logic [7:0] mem_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) mem_q[i] <= LCD_SPACE;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < 32; i++) mem_q[i] <= LCD_SPACE;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

  always_comb begin
    flat_o = '0;
    for (int unsigned i = 0; i < 32; i++) flat_o[255 - 8*i -: 8] = mem_q[i];
  end

endmodule

// File: rtl/lcd_panel_responder.sv
// Receiving end of an 8-bit HD44780 bus: captures strobes, executes
// instructions on the EN falling edge, keeps DDRAM and answers reads.
module lcd_panel_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 64,
  parameter int unsigned CMD_CYCLES   = 2,
  parameter bit          STRICT_BUSY  = 1'b0
) (
  input  logic         CLOCK,
  input  logic         ASYNC_RST,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic         LCD_EN,
  input  logic [7:0]   LCD_DATA_IN,
  output logic [7:0]   LCD_DATA_OUT,
  output logic         LCD_DATA_OE,
  output logic [255:0] display,
  output logic [6:0]   addr_counter,
  output logic         busy,
  output logic         busy_violation,
  output logic         unsupported
);

  localparam int unsigned CNT_W = 16;

  logic             en_q, rs_q, rw_q;
  logic [7:0]       data_q;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d;
  panel_cfg_t       cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             viol_q, viol_d, unsup_q, unsup_d;
  logic             commit, mem_we, mem_clr;
  logic [7:0]       mem_rdata;
  op_e              op;

  assign commit  = en_q & ~LCD_EN;
  assign op      = decode_op(data_q);
  assign busy    = (cnt_q != '0);
  assign cnt_dec = busy ? cnt_q - 1'b1 : '0;

  always_comb begin
    ac_d    = ac_q;
    inc_d   = inc_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_dec;
    viol_d  = viol_q;
    unsup_d = unsup_q;
    mem_we  = 1'b0;
    mem_clr = 1'b0;
    if (commit) begin
      if (STRICT_BUSY && !rw_q && busy) begin
        viol_d = 1'b1;
      end else if (rw_q) begin
        // Status reads leave everything untouched.
        if (rs_q) begin
          ac_d  = ac_step(ac_q, inc_q);
          cnt_d = CNT_W'(CMD_CYCLES);
        end
      end else if (rs_q) begin
        mem_we = on_screen(ac_q);
        ac_d   = ac_step(ac_q, inc_q);
        cnt_d  = CNT_W'(CMD_CYCLES);
      end else begin
        cnt_d = CNT_W'(CMD_CYCLES);
        case (op)
          OP_DDRAM:   ac_d = data_q[6:0];
          OP_CGRAM:   unsup_d = 1'b1;
          OP_FUNC:    {cfg_d.dl, cfg_d.n, cfg_d.f} = data_q[4:2];
          OP_SHIFT: begin
            if (data_q[3]) unsup_d = 1'b1;
            else           ac_d = ac_step(ac_q, data_q[2]);
          end
          OP_DISPLAY: {cfg_d.d, cfg_d.c, cfg_d.b} = data_q[2:0];
          OP_ENTRY:   inc_d = data_q[1];
          OP_HOME: begin
            ac_d  = LINE1_BASE;
            cnt_d = CNT_W'(CLEAR_CYCLES);
          end
          OP_CLEAR: begin
            mem_clr = 1'b1;
            ac_d    = LINE1_BASE;
            inc_d   = 1'b1;
            cnt_d   = CNT_W'(CLEAR_CYCLES);
          end
          default:    cnt_d = cnt_dec;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      ac_q    <= '0;
      inc_q   <= 1'b1;
      cfg_q   <= '0;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
      unsup_q <= 1'b0;
    end else begin
      en_q <= LCD_EN;
      if (LCD_EN) begin
        rs_q   <= LCD_RS;
        rw_q   <= LCD_RW;
        data_q <= LCD_DATA_IN;
      end
      ac_q    <= ac_d;
      inc_q   <= inc_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      viol_q  <= viol_d;
      unsup_q <= unsup_d;
    end
  end

  lcd_ddram_buffer u_ddram (
    .clk_i   (CLOCK),
    .rst_ni  (ASYNC_RST),
    .we_i    (mem_we),
    .clr_i   (mem_clr),
    .widx_i  (cell_idx(ac_q)),
    .wdata_i (data_q),
    .ridx_i  (cell_idx(ac_q)),
    .rdata_o (mem_rdata),
    .flat_o  (display)
  );

  assign LCD_DATA_OE    = LCD_RW & LCD_EN;
  assign LCD_DATA_OUT   = (LCD_DATA_OE && !LCD_RS) ? {busy, ac_q}
                        : (on_screen(ac_q) ? mem_rdata : LCD_SPACE);
  assign addr_counter   = ac_q;
  assign busy_violation = viol_q;
  assign unsupported    = unsup_q;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed bench for lcd_panel_responder: a lenient instance (defaults) and a
// strict-busy instance with a short clear time.
module tb_lcd_panel_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic rs = 0, rw = 0, en = 0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic oe, busy, viol, unsup;
  logic [255:0] disp;
  logic [6:0] ac;

  logic rs_b = 0, rw_b = 0, en_b = 0;
  logic [7:0] din_b = '0;
  logic [7:0] dout_b;
  logic oe_b, busy_b, viol_b, unsup_b;
  logic [255:0] disp_b;
  logic [6:0] ac_b;

  lcd_panel_responder dut (
    .CLOCK(clk), .ASYNC_RST(rst_n), .LCD_RS(rs), .LCD_RW(rw), .LCD_EN(en),
    .LCD_DATA_IN(din), .LCD_DATA_OUT(dout), .LCD_DATA_OE(oe), .display(disp),
    .addr_counter(ac), .busy(busy), .busy_violation(viol), .unsupported(unsup)
  );

  lcd_panel_responder #(.CLEAR_CYCLES(8), .CMD_CYCLES(2), .STRICT_BUSY(1'b1)) dut_b (
    .CLOCK(clk), .ASYNC_RST(rst_n), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_EN(en_b),
    .LCD_DATA_IN(din_b), .LCD_DATA_OUT(dout_b), .LCD_DATA_OE(oe_b), .display(disp_b),
    .addr_counter(ac_b), .busy(busy_b), .busy_violation(viol_b), .unsupported(unsup_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_disp;
  logic [255:0] blank;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One EN pulse; data is scrambled after EN drops so the capture is what commits.
  task automatic xfer(input bit b, input logic r_s, input logic r_w, input logic [7:0] d);
    if (b) begin rs_b = r_s; rw_b = r_w; din_b = d; en_b = 1'b1; end
    else   begin rs = r_s; rw = r_w; din = d; en = 1'b1; end
    tick(1);
    if (b) begin en_b = 1'b0; din_b = ~d; end
    else   begin en = 1'b0; din = ~d; end
    tick(1);
  endtask

  task automatic cmd(input logic [7:0] d); xfer(1'b0, 1'b0, 1'b0, d); endtask
  task automatic wr(input logic [7:0] d);  xfer(1'b0, 1'b1, 1'b0, d); endtask

  initial begin
    blank = {32{8'h20}};
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_display", disp, blank);
    check("rst_ac", ac, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", oe, 0);
    check("rst_dout", dout, 8'h20);
    check("rst_flags", {viol, unsup}, 0);

    cmd(8'h38); cmd(8'h06); cmd(8'h01); wr(8'h41); wr(8'h42);
    exp_disp = blank;
    exp_disp[255:240] = 16'h4142;
    check("line1_write", disp, exp_disp);
    check("line1_ac", ac, 7'h02);

    cmd(8'hC0); wr(8'h5A);
    exp_disp[127:120] = 8'h5A;
    check("line2_write", disp, exp_disp);
    check("line2_ac", ac, 7'h41);

    cmd(8'h8F); wr(8'h33);
    exp_disp[135:128] = 8'h33;
    check("col15_write", disp, exp_disp);
    check("col15_ac", ac, 7'h10);

    cmd(8'hA7); wr(8'h44);
    check("offscreen_drop", disp, exp_disp);
    check("wrap_27_40", ac, 7'h40);

    cmd(8'h04); cmd(8'h80); wr(8'h55);
    exp_disp[255:248] = 8'h55;
    check("dec_write", disp, exp_disp);
    check("wrap_00_67", ac, 7'h67);

    cmd(8'h14);
    check("cursor_right_wrap", ac, 7'h00);
    cmd(8'h10);
    check("cursor_left_wrap", ac, 7'h67);
    check("unsup_clear", unsup, 0);
    cmd(8'h1C);
    check("display_shift_unsup", unsup, 1);
    check("display_shift_ac", ac, 7'h67);

    cmd(8'h06); cmd(8'h80);
    tick(3);
    rs = 1'b1; rw = 1'b1; en = 1'b1; #1;
    check("data_read_val", dout, 8'h55);
    check("data_read_oe", oe, 1);
    tick(1);
    en = 1'b0; #1;
    check("oe_low", oe, 0);
    tick(1);
    check("read_ac_step", ac, 7'h01);
    check("read_busy", busy, 1);
    tick(1);
    check("read_busy_hold", busy, 1);
    tick(1);
    check("read_busy_end", busy, 0);

    xfer(1'b0, 1'b0, 1'b1, 8'h00);
    check("status_no_busy", busy, 0);
    check("status_no_ac", ac, 7'h01);

    cmd(8'hA8);
    rs = 1'b1; rw = 1'b1; en = 1'b1; #1;
    check("offscreen_read", dout, 8'h20);
    tick(1); en = 1'b0; tick(1);
    check("wrap_28_40", ac, 7'h40);

    tick(3);
    cmd(8'h00);
    check("nop_no_busy", busy, 0);
    cmd(8'h02);
    check("home_ac", ac, 0);
    check("home_busy", busy, 1);

    cmd(8'h01);
    rs = 1'b0; rw = 1'b1; en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("clear_status_busy", dout, 8'h80);
      @(posedge clk); #1;
    end
    #1;
    check("clear_status_done", dout, 8'h00);
    check("clear_display", disp, blank);
    en = 1'b0;
    tick(2);

    wr(8'h61); wr(8'h62);
    exp_disp = blank;
    exp_disp[255:240] = 16'h6162;
    check("back_to_back", disp, exp_disp);
    check("back_to_back_ac", ac, 7'h02);

    cmd(8'h80);
    for (int i = 0; i < 16; i++) wr(8'(8'h21 + 5*i));
    cmd(8'hC0);
    for (int i = 16; i < 32; i++) wr(8'(8'h21 + 5*i));
    for (int i = 0; i < 32; i++) exp_disp[255 - 8*i -: 8] = 8'(8'h21 + 5*i);
    check("pattern_display", disp, exp_disp);
    check("pattern_ac", ac, 7'h50);

    rs = 1'b1; rw = 1'b0; din = 8'h77; en = 1'b1;
    tick(1);
    rst_n = 1'b0; #2;
    check("async_rst_display", disp, blank);
    check("async_rst_ac", ac, 0);
    check("async_rst_unsup", unsup, 0);
    en = 1'b0; #2;
    rst_n = 1'b1;
    tick(2);
    check("no_stale_commit", disp, blank);
    check("no_stale_ac", ac, 0);

    xfer(1'b1, 1'b0, 1'b0, 8'h01);
    xfer(1'b1, 1'b1, 1'b0, 8'h41);
    check("strict_dropped", disp_b, blank);
    check("strict_violation", viol_b, 1);
    check("strict_ac", ac_b, 0);
    check("strict_still_busy", busy_b, 1);
    tick(10);
    check("strict_idle", busy_b, 0);
    xfer(1'b1, 1'b1, 1'b0, 8'h41);
    exp_disp = blank;
    exp_disp[255:248] = 8'h41;
    check("strict_write_ok", disp_b, exp_disp);
    check("strict_violation_sticky", viol_b, 1);
    tick(3);
    xfer(1'b1, 1'b0, 1'b0, 8'h40);
    check("cgram_unsup", unsup_b, 1);
    check("lenient_no_violation", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
